antilog_shift: RTL
==================

// Module: antilog_shift
// PURPOSE
//  Fixed-point exp2 (antilog) stage of the softmax datapath; inverse of the log2 leading-one/shift stage.
//  Splits a signed Q(INT).(FRAC) exponent x into integer part k and fraction f; outputs 2^x ~= (1+f)*2^k.
//  Output is unsigned Q(INT).(FRAC), matching the output-buffer word format.
//  3-stage valid/ready pipeline; sits after the max-subtract/scale step, before normalisation.
// PARAMETERS
//  DW    32  data width (= `OUTPUT_BUF_DATASIZE); must equal INT+FRAC
//  INT   10  integer bits (= `FIXPOINT_INT); signed on input, unsigned on output
//  FRAC  22  fraction bits (= `FIXPOINT_FRAC)
// PORTS
//  clk        in   1    clock; all logic on rising edge
//  rst        in   1    synchronous reset, active high
//  in_valid   in   1    input word valid
//  in_ready   out  1    block accepts input this cycle
//  in         in   DW   exponent x, two's-complement Q(INT).(FRAC)
//  out_valid  out  1    result valid
//  out_ready  in   1    downstream accepts result
//  out        out  DW   2^x, unsigned Q(INT).(FRAC), saturated
//  out_ovf    out  1    result saturated high (qualifies out)
//  out_unf    out  1    result flushed to zero (qualifies out)
// BEHAVIOUR
//  Reset: all stage valids, out_valid, out, out_ovf and out_unf = 0. in_ready = 1 in the cycle after reset.
//  Reset mid-operation drops in-flight words; nothing is emitted for them.
//  Handshake:
//   - Transfer on valid&ready at each end.
//   - out/out_ovf/out_unf hold stable while out_valid=1 and out_ready=0.
//   - adv = ~out_valid | out_ready. All three stages advance together when adv=1; in_ready = adv.
//   - Bubbles are not compressed.
//  Latency: exactly 3 cycles from input handshake to out_valid with no stall; throughput 1/cycle.
//  S1 (register):
//   - k = in[DW-1:FRAC], signed INT bits, floor of x.
//   - M = {1'b1, in[FRAC-1:0]}, FRAC+1 bits; value 1.f with 1.0 = 1<<FRAC.
//   - ovf = (k >= INT). unf = (k < -FRAC).
//   - shl = k[3:0] when k>=0; shr = -k when k<0. Width sized to hold FRAC.
//  S2 (register): sh = ovf|unf ? 0 : (k>=0 ? M<<shl : M>>shr). DW bits; right shift truncates (floor).
//  S3 (output register):
//   - out = ovf ? {DW{1'b1}} : unf ? 0 : sh. out_ovf/out_unf = flags.
//   - Flags are mutually exclusive.
//  Width rules:
//   - k = INT-1 gives M<<(INT-1) < 2^DW, so no saturation is needed.
//   - k = -FRAC gives out = 1 LSB.
//  Simultaneous accept at input and output while full: legal, no loss or duplication.
// TESTING
//  T1 in=0x0000_0000 (1 pulse) -> 3 cycles later out_valid=1, out=0x0040_0000 (1.0), flags 0.
//  T2 back-to-back in=0x0060_0000 (1.5), 0xFFC0_0000 (-1.0), 0xFFE0_0000 (-0.5)
//     -> out 0x00C0_0000, 0x0020_0000, 0x0030_0000 on consecutive cycles.
//  T3 in=0x0240_0000 (9.0) -> 0x8000_0000, ovf=0.
//     in=0x0280_0000 (10.0) -> 0xFFFF_FFFF, out_ovf=1.
//     in=0x7FFF_FFFF -> 0xFFFF_FFFF, out_ovf=1.
//  T4 in=0xFA80_0000 (-22.0) -> 0x0000_0001, unf=0.
//     in=0xFA40_0000 (-23.0) -> 0x0000_0000, out_unf=1.
//     in=0x8000_0000 -> 0, out_unf=1.
//  T5 out_ready=0 while 5 words are offered -> 3 accepted, then in_ready=0 and out held stable.
//     Release out_ready -> all 5 emerge in order, no loss or duplication.
//  T6 rst=1 for 1 cycle with 2 words in flight -> out_valid=0 and out=0 next cycle.
//     Flushed words never appear. A new word after reset has 3-cycle latency.

Source files
------------

// File: rtl/antilog_shift.sv
// rtl/antilog_shift.sv - fixed-point exp2 stage: x -> (1+f)*2^k, 3-stage valid/ready pipeline
module antilog_shift #(
   parameter int DW   = 32,
   parameter int INT  = 10,
   parameter int FRAC = 22
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out,
   output logic          out_ovf,
   output logic          out_unf
);

   // Shift amounts never exceed FRAC (right) or INT-1 (left).
   localparam int SHW = $clog2(FRAC + 1);

   // Exponent bounds: k >= INT cannot be represented, k < -FRAC rounds below 1 LSB.
   localparam logic signed [INT:0] K_MAX = (INT+1)'(INT);
   localparam logic signed [INT:0] K_MIN = (INT+1)'(-FRAC);

   logic                 adv;
   logic signed [INT:0]  k_in;
   logic [SHW-1:0]       shr_in;

   // Stage 1 registers
   logic                 v1;
   logic [FRAC:0]        m1;
   logic                 ovf1;
   logic                 unf1;
   logic                 neg1;
   logic [SHW-1:0]       shl1;
   logic [SHW-1:0]       shr1;

   // Stage 2 registers
   logic                 v2;
   logic [DW-1:0]        sh2;
   logic                 ovf2;
   logic                 unf2;

   logic [DW-1:0]        m_ext;

   // The whole pipeline moves as one unit; a stall anywhere freezes every stage.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Integer part of x, sign-extended by one bit so the bound compares never wrap.
   assign k_in   = {in[DW-1], in[DW-1:FRAC]};
   // -k taken modulo 2^SHW; only meaningful when k is negative and not underflowing.
   assign shr_in = ~k_in[SHW-1:0] + SHW'(1);

   assign m_ext  = {{(DW-FRAC-1){1'b0}}, m1};

   // S1: split x into mantissa 1.f and exponent k, classify range.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         m1   <= '0;
         ovf1 <= 1'b0;
         unf1 <= 1'b0;
         neg1 <= 1'b0;
         shl1 <= '0;
         shr1 <= '0;
      end else if (adv) begin
         v1   <= in_valid;
         m1   <= {1'b1, in[FRAC-1:0]};
         ovf1 <= in_valid & (k_in >= K_MAX);
         unf1 <= in_valid & (k_in < K_MIN);
         neg1 <= k_in[INT];
         shl1 <= k_in[SHW-1:0];
         shr1 <= shr_in;
      end
   end

   // S2: barrel shift the mantissa by k; right shifts truncate toward zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2   <= 1'b0;
         sh2  <= '0;
         ovf2 <= 1'b0;
         unf2 <= 1'b0;
      end else if (adv) begin
         v2   <= v1;
         ovf2 <= ovf1;
         unf2 <= unf1;
         if (ovf1 | unf1) begin
            sh2 <= '0;
         end else if (neg1) begin
            sh2 <= m_ext >> shr1;
         end else begin
            sh2 <= m_ext << shl1;
         end
      end
   end

   // S3: saturate or flush, and present the result to the downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         out_ovf   <= 1'b0;
         out_unf   <= 1'b0;
      end else if (adv) begin
         out_valid <= v2;
         out_ovf   <= ovf2;
         out_unf   <= unf2;
         if (ovf2) begin
            out <= '1;
         end else if (unf2) begin
            out <= '0;
         end else begin
            out <= sh2;
         end
      end
   end

endmodule
